// File: rtl/memory_loader.sv
// Boot-time image loader: parses a length/payload/XOR-checksum byte frame and emits one
// word write per four payload bytes, holding the CPU in reset until the image verifies.
module memory_loader #(
  parameter int unsigned Depth = 512
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        mem_write_enable_o,
  output logic [31:0] mem_write_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned IdxW = $clog2(Depth + 1);

  typedef enum logic [2:0] {StIdle, StHeader, StData, StCheck, StDone, StError} state_e;

  state_e            state_q, state_d;
  logic [31:0]       len_q, len_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic [7:0]        xor_q, xor_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              in_ready_q, cpu_hold_q, busy_q, done_q, error_q;

  logic              accept;
  logic [31:0]       hdr_word;
  logic              last_word;

  assign accept    = in_valid_i & in_ready_q;
  assign hdr_word  = {in_data_i, len_q[31:8]};
  assign last_word = (32'(widx_q) + 32'd1) == len_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    widx_d  = widx_q;
    xor_d   = xor_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d = StHeader;
          len_d   = '0;
          bcnt_d  = '0;
          widx_d  = '0;
          xor_d   = '0;
        end
      end
      StHeader: begin
        if (accept) begin
          len_d  = hdr_word;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (hdr_word > 32'(Depth)) state_d = StError;
            else if (hdr_word == 32'd0) state_d = StCheck;
            else state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          xor_d  = xor_q ^ in_data_i;
          word_d = {in_data_i, word_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = 32'({widx_q, 2'b00});
            wdata_d = {in_data_i, word_q};
            widx_d  = widx_q + 1'b1;
            if (last_word) state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (accept) state_d = (in_data_i == xor_q) ? StDone : StError;
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      bcnt_q     <= '0;
      widx_q     <= '0;
      xor_q      <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      widx_q     <= widx_d;
      xor_q      <= xor_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      in_ready_q <= state_d inside {StHeader, StData, StCheck};
      busy_q     <= state_d inside {StHeader, StData, StCheck};
      cpu_hold_q <= state_d != StDone;
      done_q     <= state_d == StDone;
      error_q    <= state_d == StError;
    end
  end

  assign in_ready_o          = in_ready_q;
  assign mem_write_enable_o  = we_q;
  assign mem_write_address_o = addr_q;
  assign mem_write_data_o    = wdata_q;
  assign cpu_hold_o          = cpu_hold_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign error_o             = error_q;

endmodule

// File: tb/tb_memory_loader.sv
// Randomized bench for memory_loader: frames are built from a byte-level model and the
// observed write stream and status flags are compared against it.
module tb_memory_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] wq[$];

  memory_loader #(.Depth(512)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .in_valid_i         (in_valid),
    .in_data_i          (in_data),
    .in_ready_o         (in_ready),
    .mem_write_enable_o (mem_we),
    .mem_write_address_o(mem_addr),
    .mem_write_data_o   (mem_data),
    .cpu_hold_o         (cpu_hold),
    .busy_o             (busy),
    .done_o             (done),
    .error_o            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every cycle with the strobe high is one write; a stuck strobe shows up as extra writes.
  always @(posedge clk) begin
    #1;
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_data});
  end

  // Model: header = N little-endian, payload words little-endian, checksum = XOR of payload.
  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] w;
    logic [7:0]  ck;
    logic [31:0] nn;
    nn = n;
    ck = 8'h00;
    frame_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back(8'((nn >> (8 * i)) & 32'hFF));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        ck = ck ^ 8'((w >> (8 * b)) & 32'hFF);
      end
      exp_q.push_back({32'(4 * i), w});
    end
    frame_q.push_back(corrupt ? (ck ^ 8'(1 << $urandom_range(0, 7))) : ck);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        start    = noise && ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    while (in_ready !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL byte_accept: in_ready=%b, required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input bit gaps, input bit noise);
    foreach (frame_q[i]) send_byte(frame_q[i], gaps, noise);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, mem_we, mem_addr, mem_data} !== 66'd0) begin
      fails++;
      $display("FAIL reset_datapath: ready=%b we=%b addr=%h data=%h, required all 0",
               in_ready, mem_we, mem_addr, mem_data);
    end
    tests++;
    if ({cpu_hold, busy, done, error} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_status: hold/busy/done/err=%b, required 1000",
               {cpu_hold, busy, done, error});
    end
  endtask

  task automatic test_spec_frame(input logic [7:0] ck, input bit expect_ok);
    logic [7:0] bytes[13];
    bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h6F, 8'h00, 8'h00, 8'h00, 8'h00};
    bytes[12] = ck;
    wq.delete();
    frame_q.delete();
    foreach (bytes[i]) frame_q.push_back(bytes[i]);
    pulse_start();
    tests++;
    if ({busy, in_ready, cpu_hold} !== 3'b111) begin
      fails++;
      $display("FAIL start_to_header: busy/ready/hold=%b, required 111",
               {busy, in_ready, cpu_hold});
    end
    send_frame(1'b0, 1'b0);
    tests++;
    if (wq.size() !== 2 || wq[0] !== {32'h0, 32'h13} || wq[1] !== {32'h4, 32'h6F}) begin
      fails++;
      $display("FAIL spec_writes: count=%0d first=%h, required 2 writes 0/13 and 4/6F",
               wq.size(), (wq.size() > 0) ? wq[0] : 64'h0);
    end
    tests++;
    if ({done, error, cpu_hold, busy, in_ready} !== (expect_ok ? 5'b10000 : 5'b01100)) begin
      fails++;
      $display("FAIL spec_status ck=%h: done/err/hold/busy/ready=%b, required %b", ck,
               {done, error, cpu_hold, busy, in_ready}, expect_ok ? 5'b10000 : 5'b01100);
    end
  endtask

  task automatic test_oversize();
    wq.delete();
    frame_q.delete();
    frame_q.push_back(8'h01);
    frame_q.push_back(8'h02);
    frame_q.push_back(8'h00);
    frame_q.push_back(8'h00);
    pulse_start();
    send_frame(1'b0, 1'b0);
    tests++;
    if ({error, done, in_ready, cpu_hold, busy} !== 5'b10010) begin
      fails++;
      $display("FAIL oversize_status: err/done/ready/hold/busy=%b, required 10010",
               {error, done, in_ready, cpu_hold, busy});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (wq.size() !== 0) begin
      fails++;
      $display("FAIL oversize_writes: count=%0d, required 0", wq.size());
    end
  endtask

  task automatic test_zero_len(input bit corrupt);
    wq.delete();
    build_frame(0, corrupt);
    pulse_start();
    send_frame(1'b0, 1'b0);
    tests++;
    if ({done, error} !== (corrupt ? 2'b01 : 2'b10) || wq.size() !== 0) begin
      fails++;
      $display("FAIL zero_len corrupt=%0d: done/err=%b writes=%0d, required %b and 0",
               corrupt, {done, error}, wq.size(), corrupt ? 2'b01 : 2'b10);
    end
  endtask

  task automatic test_random_frame(input int n, input bit corrupt, input bit noise);
    int bad;
    wq.delete();
    build_frame(n, corrupt);
    pulse_start();
    send_frame(1'b1, noise);
    tests++;
    if (wq.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL rand_count n=%0d: writes=%0d, required %0d", n, wq.size(), exp_q.size());
    end
    bad = 0;
    foreach (exp_q[i]) begin
      if (i < wq.size() && wq[i] !== exp_q[i]) begin
        if (bad == 0)
          $display("FAIL rand_word n=%0d idx=%0d: addr/data=%h, required %h",
                   n, i, wq[i], exp_q[i]);
        bad++;
      end
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if ({done, error, cpu_hold} !== (corrupt ? 3'b011 : 3'b100)) begin
      fails++;
      $display("FAIL rand_status n=%0d: done/err/hold=%b, required %b", n,
               {done, error, cpu_hold}, corrupt ? 3'b011 : 3'b100);
    end
  endtask

  task automatic test_reset_midframe();
    wq.delete();
    build_frame(2, 1'b0);
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(frame_q[i], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    tests++;
    if ({in_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, error} !==
        {66'd0, 4'b1000}) begin
      fails++;
      $display("FAIL midframe_reset: ready=%b we=%b addr=%h data=%h hold/busy/done/err=%b",
               in_ready, mem_we, mem_addr, mem_data, {cpu_hold, busy, done, error});
    end
    repeat (3) @(negedge clk);
    tests++;
    if (wq.size() !== 1 || wq[0] !== exp_q[0]) begin
      fails++;
      $display("FAIL midframe_writes: count=%0d, required 1 (first full word only)",
               wq.size());
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_random_frame(3, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_spec_frame(8'h7C, 1'b1);
    test_spec_frame(8'h00, 1'b0);
    test_oversize();
    test_zero_len(1'b0);
    test_zero_len(1'b1);
    test_random_frame($urandom_range(1, 20), 1'b0, 1'b0);
    test_random_frame($urandom_range(1, 20), 1'b1, 1'b0);
    test_random_frame(512, 1'b0, 1'b1);
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_loader.md
# memory_loader

Boot-time writer for the instruction/data memory of the RISC-V core. Receives a framed little-endian byte stream (length header, payload, checksum) over a valid/ready byte interface and emits one 32-bit word write per 4 payload bytes on the memory write port. It holds the CPU in reset until an image has loaded and verified. It sits between the host-facing byte source (UART receiver or bench) and the byte-addressed, little-endian, word-organised program memory.

## Interface

- `depth`, 512, memory size in 32-bit words; byte address space is 0 .. 4*depth-1
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; arms the loader from IDLE, DONE or ERROR
- `in_valid`  in  1  byte source has a byte
- `in_data`  in  8  byte value
- `in_ready`  out  1  loader accepts the byte this cycle; transfer occurs when `in_valid & in_ready` at a rising edge
- `mem_write_enable`  out  1  one-cycle write strobe
- `mem_write_address`  out  32  byte address, always word aligned
- `mem_write_data`  out  32  word; byte at address+0 in bits [7:0], address+3 in bits [31:24]
- `cpu_hold`  out  1  keep CPU in reset
- `busy`  out  1  frame reception in progress
- `done`  out  1  image loaded and checksum correct
- `error`  out  1  frame rejected (length or checksum)

## Operation

- Frame: 4 header bytes = word count N (32-bit, little-endian), then 4*N payload bytes, then 1 checksum byte = XOR of all payload bytes (0x00 when N = 0).
- States: IDLE, HEADER, DATA, CHECK, DONE, ERROR.
- IDLE: `in_ready`=0. `start` -> HEADER.
- HEADER: `in_ready`=1; bytes shift into the length register (first byte = bits [7:0]). On the 4th accepted byte: N > depth -> ERROR (no writes); N = 0 -> CHECK; else DATA.
- DATA: `in_ready`=1; bytes assemble into a word (first byte = bits [7:0]); running XOR updates on every payload byte. On each 4th byte the word is written at address 4*word_index and word_index increments. After the N-th word -> CHECK.
- CHECK: `in_ready`=1; accept one byte; equal to running XOR -> DONE, otherwise ERROR.
- DONE / ERROR: `in_ready`=0; `start` -> HEADER with byte counter, word index, length and XOR cleared.
- `start` in HEADER, DATA or CHECK is ignored.
- Outputs by state: `busy`=1 in HEADER/DATA/CHECK; `done`=1 only in DONE; `error`=1 only in ERROR; `cpu_hold`=1 in every state except DONE.
- Words already written before an error stay in memory; the loader never rewrites or clears them.
- Word index counter is wide enough to hold `depth`; no address ever reaches 4*depth.

## Timing

- Reset (asynchronous, active-low): state IDLE, `in_ready`=0, `mem_write_enable`=0, `mem_write_address`=0, `mem_write_data`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0; all counters, length and XOR register cleared. Reset asserted mid-frame abandons the frame; a partially assembled word is never written.
- `start` sampled at a rising edge; state is HEADER the next cycle.
- Write latency: `mem_write_enable`, address and data are registered and valid for exactly one cycle, the cycle after the edge that accepted the word's 4th byte.
- Throughput: one byte per cycle with no bubbles; a new byte may be accepted in the same cycle as a write strobe.
- `in_valid` low stalls without state change; `in_data` is ignored when `in_valid & in_ready` is 0.
- Final word write and the DATA->CHECK transition take effect on the same edge; the checksum byte may arrive the very next cycle.
- DONE/ERROR, and the matching `done`/`error`/`cpu_hold` values, are visible the cycle after the checksum byte (or the 4th header byte for an oversize length) is accepted.

## Test plan

- Reset then `start`; stream 02 00 00 00, 13 00 00 00, 6F 00 00 00, checksum 7C -> writes 0x00000013 @0 and 0x0000006F @4, each a 1-cycle strobe; `done`=1, `cpu_hold`=0.
- Same frame with checksum 00 -> both writes occur, then `error`=1, `done`=0, `cpu_hold`=1.
- Header 01 02 00 00 (N=513 > 512) -> ERROR the next cycle, no write strobes, `in_ready`=0.
- Header 00 00 00 00, checksum 00 -> DONE with no writes; checksum 01 instead -> ERROR.
- Full frame of N=512 with `in_valid` toggling randomly -> 512 writes at addresses 0..0x7FC, no byte lost, `done`=1; extra `start` pulses mid-frame change nothing.
- Assert `reset` after 6 payload bytes -> all outputs at reset values immediately, no write for the partial word; `start` plus a fresh frame then loads correctly.
